// File: rtl/direction_arbiter_if.sv
// -----------------------------------------------------------------------------
// direction_arbiter_if
//
// Bundles the button, tick and restart inputs together with the committed
// direction, delayed tick and drop outputs of direction_arbiter.
//
// Signals
//   i_up, i_down, i_left, i_right  raw asynchronous buttons, active high
//   i_phase                        game tick, every toggle is one game step
//   i_restart                      synchronous flush request, active high
//   o_up, o_down, o_left, o_right  committed direction, one-hot or all-zero
//   o_phase                        i_phase delayed, consumed by the game core
//   o_drop                         one-cycle pulse when a press is discarded
//
// Modports
//   master  board / testbench side (drives i_*, observes o_*)
//   slave   arbiter side (observes i_*, drives o_*)
// -----------------------------------------------------------------------------
interface direction_arbiter_if;

  logic i_up;
  logic i_down;
  logic i_left;
  logic i_right;
  logic i_phase;
  logic i_restart;

  logic o_up;
  logic o_down;
  logic o_left;
  logic o_right;
  logic o_phase;
  logic o_drop;

  modport master (
    output i_up, i_down, i_left, i_right, i_phase, i_restart,
    input  o_up, o_down, o_left, o_right, o_phase, o_drop
  );

  modport slave (
    input  i_up, i_down, i_left, i_right, i_phase, i_restart,
    output o_up, o_down, o_left, o_right, o_phase, o_drop
  );

endinterface

// File: rtl/direction_arbiter.sv
// -----------------------------------------------------------------------------
// direction_arbiter
//
// Conditions the four raw direction buttons for the snake game core and
// schedules at most one direction change per game step. Each button is
// synchronised, debounced and edge-detected; simultaneous presses are
// arbitrated with fixed priority up > down > left > right; accepted presses
// are buffered in a 2-entry FIFO. One entry is released into the committed
// direction on every game tick, and the tick is forwarded one cycle after the
// direction outputs have settled.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples required to accept a button
//                    level change (>= 2)
//
// Ports
//   clk    game/VGA clock
//   rst_n  synchronous, active-low reset
//   bus    direction_arbiter_if.slave (buttons, tick, restart in;
//          committed direction, delayed tick, drop pulse out)
//
// Configuration
//   DIRECTION_ARBITER_REVERSAL_FILTER_EN  when defined, a press opposite the
//   reference direction is dropped; otherwise it is queued and left for the
//   game core to reject.
// -----------------------------------------------------------------------------
module direction_arbiter #(
  parameter int DEBOUNCE_CYCLES = 251740
) (
  input  logic                clk,
  input  logic                rst_n,
  direction_arbiter_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CountLast = CW'(DEBOUNCE_CYCLES - 1);

  // Direction codes; the opposite of any direction is its code with bit 0
  // flipped (up/down, left/right).
  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirRight = 2'd3;

  // ---------------------------------------------------------------------------
  // Button front end: synchroniser, debouncer, rising-edge detector.
  // Bit index equals the direction code.
  // ---------------------------------------------------------------------------
  logic [3:0]    rawButtons;
  logic [3:0]    syncMeta_q;
  logic [3:0]    syncStable_q;
  logic [3:0]    level_q;
  logic [3:0]    level_d;
  logic [3:0]    levelPrev_q;
  logic [CW-1:0] count_q [4];
  logic [CW-1:0] count_d [4];
  logic [3:0]    pressEvents;

  assign rawButtons = {bus.i_right, bus.i_left, bus.i_down, bus.i_up};

  // A level change is accepted only after the synchronised value has differed
  // from the debounced level for DEBOUNCE_CYCLES consecutive samples; any
  // sample that agrees with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    count_d = count_q;
    for (int b = 0; b < 4; b++) begin
      if (syncStable_q[b] == level_q[b]) begin
        count_d[b] = '0;
      end else if (count_q[b] == CountLast) begin
        level_d[b] = syncStable_q[b];
        count_d[b] = '0;
      end else begin
        count_d[b] = count_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncMeta_q   <= '0;
      syncStable_q <= '0;
      level_q      <= '0;
      levelPrev_q  <= '0;
      for (int b = 0; b < 4; b++) begin
        count_q[b] <= '0;
      end
    end else begin
      syncMeta_q   <= rawButtons;
      syncStable_q <= syncMeta_q;
      level_q      <= level_d;
      levelPrev_q  <= level_q;
      count_q      <= count_d;
    end
  end

  // Only presses create events; releases are ignored.
  assign pressEvents = level_q & ~levelPrev_q;

  // ---------------------------------------------------------------------------
  // Arbitration: the highest-priority press becomes the candidate, every other
  // simultaneous press is a loser and causes a drop.
  // ---------------------------------------------------------------------------
  logic       candValid;
  logic [1:0] candDir;
  logic       lostPress;

  always_comb begin
    candValid = 1'b0;
    candDir   = DirUp;
    lostPress = 1'b0;
    if (pressEvents[0]) begin
      candValid = 1'b1;
      candDir   = DirUp;
      lostPress = |pressEvents[3:1];
    end else if (pressEvents[1]) begin
      candValid = 1'b1;
      candDir   = DirDown;
      lostPress = |pressEvents[3:2];
    end else if (pressEvents[2]) begin
      candValid = 1'b1;
      candDir   = DirLeft;
      lostPress = pressEvents[3];
    end else if (pressEvents[3]) begin
      candValid = 1'b1;
      candDir   = DirRight;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue, committed direction, step detection and drop register.
  // ---------------------------------------------------------------------------
  logic [1:0] queue_q [2];
  logic [1:0] queue_d [2];
  logic [1:0] queueCount_q;
  logic [1:0] queueCount_d;
  logic       committedValid_q;
  logic       committedValid_d;
  logic [1:0] committedDir_q;
  logic [1:0] committedDir_d;
  logic       phase_q;
  logic       phaseOut_q;
  logic       drop_q;
  logic       drop_d;

  logic       step;
  logic       queueEmpty;
  logic       queueFull;
  logic       refValid;
  logic [1:0] refDir;
  logic       sameAsRef;
  logic       reversal;
  logic       fullBlock;
  logic       pushOk;
  logic       popOk;

  assign step       = (bus.i_phase != phase_q);
  assign queueEmpty = (queueCount_q == 2'd0);
  assign queueFull  = (queueCount_q == 2'd2);

  // The filter compares against the newest queued entry, or the committed
  // direction when nothing is queued; this is always the pre-pop view, so a
  // pop in the same cycle does not change what the candidate is tested against.
  assign refValid = !queueEmpty || committedValid_q;
  assign refDir   = queueEmpty ? committedDir_q
                  : (queueFull ? queue_q[1] : queue_q[0]);

  assign sameAsRef = refValid && (candDir == refDir);

`ifdef DIRECTION_ARBITER_REVERSAL_FILTER_EN
  assign reversal = refValid && (candDir == (refDir ^ 2'b01));
`else
  assign reversal = 1'b0;
`endif

  // A full queue still accepts the candidate if a step frees a slot this cycle.
  assign fullBlock = queueFull && !step;

  assign pushOk = candValid && !bus.i_restart && !sameAsRef && !reversal && !fullBlock;
  assign popOk  = step && !queueEmpty;

  // Losers and rejected candidates collapse into a single drop pulse; restart
  // silences drops entirely.
  assign drop_d = !bus.i_restart && (lostPress || (candValid && !pushOk));

  // Pop shifts the second entry to the head before the push writes the new
  // tail at the post-pop fill level.
  always_comb begin
    queue_d          = queue_q;
    queueCount_d     = queueCount_q;
    committedValid_d = committedValid_q;
    committedDir_d   = committedDir_q;
    if (bus.i_restart) begin
      queueCount_d     = 2'd0;
      committedValid_d = 1'b0;
      committedDir_d   = DirUp;
    end else begin
      if (popOk) begin
        committedValid_d = 1'b1;
        committedDir_d   = queue_q[0];
        queue_d[0]       = queue_q[1];
        queueCount_d     = queueCount_q - 2'd1;
      end
      if (pushOk) begin
        queue_d[queueCount_d[0]] = candDir;
        queueCount_d             = queueCount_d + 2'd1;
      end
    end
  end

  // o_phase trails phase_q by one cycle so the direction outputs, updated on
  // the edge that ends the step cycle, are stable before the game sees the tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      queue_q[0]       <= DirUp;
      queue_q[1]       <= DirUp;
      queueCount_q     <= 2'd0;
      committedValid_q <= 1'b0;
      committedDir_q   <= DirUp;
      phase_q          <= 1'b0;
      phaseOut_q       <= 1'b0;
      drop_q           <= 1'b0;
    end else begin
      queue_q          <= queue_d;
      queueCount_q     <= queueCount_d;
      committedValid_q <= committedValid_d;
      committedDir_q   <= committedDir_d;
      phase_q          <= bus.i_phase;
      phaseOut_q       <= phase_q;
      drop_q           <= drop_d;
    end
  end

  assign bus.o_up    = committedValid_q && (committedDir_q == DirUp);
  assign bus.o_down  = committedValid_q && (committedDir_q == DirDown);
  assign bus.o_left  = committedValid_q && (committedDir_q == DirLeft);
  assign bus.o_right = committedValid_q && (committedDir_q == DirRight);
  assign bus.o_phase = phaseOut_q;
  assign bus.o_drop  = drop_q;

endmodule
